// File: rtl/serdes_lb_checker.sv
// serdes_lb_checker: loopback pattern checker; finds lane rotation, locks, counts words/errors (ports: rx_clk_i, rx_rst_i, en_i, cnt_clr_i, rx_data_i, rx_char_is_k_i, rx_not_in_table_i, rx_disp_err_i -> state_o, locked_o, lane_o, err_o, err_cnt_o, word_cnt_o)
module serdes_lb_checker #(
  parameter logic [63:0] EXP_WORD   = 64'h0000_0000_00CA_FE1C,
  parameter logic [7:0]  EXP_K      = 8'h01,
  parameter int          LOCK_CNT   = 4,
  parameter int          UNLOCK_CNT = 4,
  parameter int          ERR_CNT_W  = 16
) (
  input  logic                 rx_clk_i,
  input  logic                 rx_rst_i,
  input  logic                 en_i,
  input  logic                 cnt_clr_i,
  input  logic [63:0]          rx_data_i,
  input  logic [7:0]           rx_char_is_k_i,
  input  logic [7:0]           rx_not_in_table_i,
  input  logic [7:0]           rx_disp_err_i,
  output logic [1:0]           state_o,
  output logic                 locked_o,
  output logic [2:0]           lane_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic [31:0]          word_cnt_o
);
  localparam logic [1:0] HUNT = 2'b00, VERIFY = 2'b01, LOCKED = 2'b10;
  function automatic logic good(input logic [2:0] r, input logic [63:0] d, input logic [7:0] k);
    logic [127:0] tw;
    logic [15:0] tk;
    tw = {EXP_WORD, EXP_WORD} << (8 * r);
    tk = {EXP_K, EXP_K} << r;
    return d == tw[127:64] && k == tk[15:8];
  endfunction
  logic [1:0] state_nxt;
  logic [2:0] cand, lane_nxt;
  logic [3:0] good_cnt, bad_cnt, good_cnt_nxt, bad_cnt_nxt;
  logic clean, cand_good, lane_good, in_lock, err_nxt, locked_nxt;
  logic [ERR_CNT_W-1:0] err_cnt_nxt;
  logic [31:0] word_cnt_nxt;
  always_comb begin
    cand = '0;
    for (int i = 0; i < 8; i++) if (rx_char_is_k_i[i]) cand = 3'(i);
  end
  assign clean     = ~|rx_not_in_table_i && ~|rx_disp_err_i;
  assign cand_good = $onehot(rx_char_is_k_i) && clean && good(cand, rx_data_i, rx_char_is_k_i);
  assign lane_good = clean && good(lane_o, rx_data_i, rx_char_is_k_i);
  always_ff @(posedge rx_clk_i or posedge rx_rst_i)
    if (rx_rst_i) state_o <= HUNT;
    else state_o <= state_nxt;
  always_comb begin
    state_nxt = state_o;
    if (!en_i) state_nxt = HUNT;
    else
      case (state_o)
        HUNT:    if (cand_good) state_nxt = (LOCK_CNT == 1) ? LOCKED : VERIFY;
        VERIFY:  state_nxt = !lane_good ? HUNT : (good_cnt + 4'd1 == 4'(LOCK_CNT)) ? LOCKED : VERIFY;
        LOCKED:  if (!lane_good && bad_cnt + 4'd1 == 4'(UNLOCK_CNT)) state_nxt = HUNT;
        default: state_nxt = HUNT;
      endcase
  end
  always_comb begin
    in_lock      = en_i && state_o == LOCKED;
    err_nxt      = in_lock && !lane_good;
    locked_nxt   = state_nxt == LOCKED;
    good_cnt_nxt = !en_i ? 4'd0 : (state_o == HUNT && cand_good) ? 4'd1 :
                   (state_o == VERIFY && lane_good) ? good_cnt + 4'd1 : 4'd0;
    bad_cnt_nxt  = err_nxt ? bad_cnt + 4'd1 : 4'd0;
    lane_nxt     = (en_i && state_o == HUNT && cand_good) ? cand : lane_o;
    err_cnt_nxt  = cnt_clr_i ? '0 : (err_nxt && ~&err_cnt_o) ? err_cnt_o + 1'b1 : err_cnt_o;
    word_cnt_nxt = cnt_clr_i ? '0 : (in_lock && ~&word_cnt_o) ? word_cnt_o + 32'd1 : word_cnt_o;
  end
  always_ff @(posedge rx_clk_i or posedge rx_rst_i)
    if (rx_rst_i) begin
      locked_o   <= 1'b0;
      lane_o     <= '0;
      err_o      <= 1'b0;
      err_cnt_o  <= '0;
      word_cnt_o <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
    end else begin
      locked_o   <= locked_nxt;
      lane_o     <= lane_nxt;
      err_o      <= err_nxt;
      err_cnt_o  <= err_cnt_nxt;
      word_cnt_o <= word_cnt_nxt;
      good_cnt   <= good_cnt_nxt;
      bad_cnt    <= bad_cnt_nxt;
    end
endmodule

// File: tb/tb_serdes_lb_checker.sv
// tb_serdes_lb_checker: directed self-checking bench for serdes_lb_checker
module tb_serdes_lb_checker;
  localparam logic [63:0] W0 = 64'h0000_0000_00CA_FE1C;
  localparam logic [63:0] W4 = 64'h00CA_FE1C_0000_0000;
  localparam logic [63:0] W4_BAD = 64'h00CA_FE1C_0000_FF00;
  localparam logic [63:0] W0_BAD = 64'h0000_0000_00CA_FF1C;
  logic clk = 1'b0, rst = 1'b0, en = 1'b1, clr = 1'b0;
  logic [63:0] data = '0;
  logic [7:0] is_k = '0, nit = '0, disp = '0;
  logic [1:0] state;
  logic locked, err;
  logic [2:0] lane;
  logic [3:0] err_cnt;
  logic [31:0] word_cnt;
  int checks = 0, errors = 0;
  serdes_lb_checker #(.ERR_CNT_W(4)) dut (
    .rx_clk_i(clk), .rx_rst_i(rst), .en_i(en), .cnt_clr_i(clr),
    .rx_data_i(data), .rx_char_is_k_i(is_k), .rx_not_in_table_i(nit), .rx_disp_err_i(disp),
    .state_o(state), .locked_o(locked), .lane_o(lane), .err_o(err),
    .err_cnt_o(err_cnt), .word_cnt_o(word_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic drive(input logic [63:0] d, input logic [7:0] k, input logic [7:0] n, input logic [7:0] p);
    data = d;
    is_k = k;
    nit = n;
    disp = p;
  endtask
  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_locked", locked, 0);
    chk("rst_lane", lane, 0);
    chk("rst_err", err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_word_cnt", word_cnt, 0);
    rst = 1'b0;
    drive(W0, 8'h01, 0, 0);
    tick();
    chk("acq0_e1_state", state, 1);
    tick();
    tick();
    chk("acq0_e3_state", state, 1);
    tick();
    chk("acq0_e4_state", state, 2);
    chk("acq0_locked", locked, 1);
    chk("acq0_lane", lane, 0);
    chk("acq0_word_cnt", word_cnt, 0);
    tick();
    chk("acq0_e5_word_cnt", word_cnt, 1);
    chk("acq0_err_cnt", err_cnt, 0);
    en = 1'b0;
    tick();
    chk("dis_state", state, 0);
    chk("dis_locked", locked, 0);
    chk("dis_word_hold", word_cnt, 1);
    en = 1'b1;
    drive(W4, 8'h10, 0, 0);
    tick();
    chk("acq4_e1_state", state, 1);
    chk("acq4_e1_lane", lane, 4);
    tick();
    tick();
    tick();
    chk("acq4_state", state, 2);
    chk("acq4_locked", locked, 1);
    chk("acq4_lane", lane, 4);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_word_cnt", word_cnt, 0);
    chk("clr_state", state, 2);
    for (int i = 0; i < 3; i++) begin
      drive(W4_BAD, 8'h10, 0, 0);
      tick();
      chk("corrupt_err", err, 1);
      chk("corrupt_locked", locked, 1);
    end
    drive(W4, 8'h10, 0, 0);
    tick();
    chk("corrupt_err_low", err, 0);
    chk("corrupt_err_cnt", err_cnt, 3);
    chk("corrupt_word_cnt", word_cnt, 4);
    for (int i = 0; i < 4; i++) begin
      drive(W4, 8'h10, 0, 8'h02);
      tick();
      chk("disp_err", err, 1);
      chk("disp_locked", locked, i < 3);
    end
    chk("unlock_state", state, 0);
    chk("unlock_err_cnt", err_cnt, 7);
    chk("unlock_lane_kept", lane, 4);
    chk("unlock_word_cnt", word_cnt, 8);
    drive(W0, 8'h11, 0, 0);
    tick();
    chk("multi_k_state", state, 0);
    drive(W0, 8'h00, 0, 0);
    tick();
    chk("zero_k_state", state, 0);
    drive(W0, 8'h01, 0, 0);
    tick();
    chk("reacq_verify", state, 1);
    chk("reacq_lane", lane, 0);
    drive(W0, 8'h01, 8'h01, 0);
    tick();
    chk("verify_bad_state", state, 0);
    chk("verify_no_err", err, 0);
    drive(W0, 8'h01, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("reacq_locked", state, 2);
    chk("reacq_err_cnt", err_cnt, 7);
    for (int i = 0; i < 8; i++) begin
      drive(W0_BAD, 8'h01, 0, 0);
      tick();
      drive(W0, 8'h01, 0, 0);
      tick();
    end
    chk("sat_reach", err_cnt, 15);
    drive(W0_BAD, 8'h01, 0, 0);
    tick();
    chk("sat_err", err, 1);
    chk("sat_hold", err_cnt, 15);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_err_cnt", err_cnt, 0);
    chk("clr_err_pulse", err, 1);
    chk("clr_word_cnt2", word_cnt, 0);
    chk("clr_locked", state, 2);
    drive(W0, 8'h01, 0, 0);
    tick();
    chk("post_clr_word", word_cnt, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    chk("mid_rst_word_cnt", word_cnt, 0);
    chk("mid_rst_lane", lane, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serdes_lb_checker.md
Name: serdes_lb_checker

Overview:
- Receive-side pattern checker for the SERDES loopback link; consumes the 64-bit RX PCS output (8b/10b decoded, 8 byte lanes) clocked by the recovered RX clock.
- The loopback transmitter sends a fixed word every cycle: lane 0 = K28.0 (0x1C, K flag set), lanes 1-2 = 0xFE, 0xCA, lanes 3-7 = 0x00.
- The checker finds the byte-lane rotation of that word, acquires lock, then counts words and errors and drops lock on sustained corruption.
- Outputs drive status LEDs and a debug readout.

Parameters:
- EXP_WORD, 64'h0000_0000_00CA_FE1C, expected data word at lane rotation 0.
- EXP_K, 8'h01, expected char_is_k pattern at rotation 0; must be one-hot.
- LOCK_CNT, 4, consecutive good words needed to lock (1..15).
- UNLOCK_CNT, 4, consecutive bad words in LOCKED needed to drop lock (1..15).
- ERR_CNT_W, 16, error counter width.

Ports:
- rx_clk_i  in  1  RX recovered clock; all logic runs on its rising edge.
- rx_rst_i  in  1  asynchronous reset, active-high.
- en_i  in  1  checker enable.
- cnt_clr_i  in  1  synchronous clear of err_cnt_o and word_cnt_o.
- rx_data_i  in  64  decoded RX data; byte lane n = bits [8n+7:8n].
- rx_char_is_k_i  in  8  per-lane K flag.
- rx_not_in_table_i  in  8  per-lane code violation.
- rx_disp_err_i  in  8  per-lane disparity error.
- state_o  out  2  00 HUNT, 01 VERIFY, 10 LOCKED.
- locked_o  out  1  high in LOCKED.
- lane_o  out  3  latched rotation.
- err_o  out  1  one-cycle pulse per counted error.
- err_cnt_o  out  ERR_CNT_W  saturating error count.
- word_cnt_o  out  32  saturating count of words checked while LOCKED.

Behaviour:
- Async reset values: state HUNT, locked_o 0, lane_o 0, err_o 0, all counters 0.
- All outputs are registered. The input word at edge k is reflected in outputs after edge k; there is no input pipeline.
- rot(x, r): byte lane n of x moves to lane (n+r) mod 8, i.e. rotate left by 8r bits.
- good(r) requires all of:
  - rx_data_i == rot(EXP_WORD, r)
  - rx_char_is_k_i == rot(EXP_K, r)
  - rx_not_in_table_i == 0
  - rx_disp_err_i == 0
- HUNT:
  - Candidate r = index of the set bit in rx_char_is_k_i. Only evaluated when exactly one bit is set; zero or multiple bits mean the word is not a candidate.
  - If the candidate is good(r): latch lane_o = r, good_cnt = 1, go to VERIFY. If LOCK_CNT == 1, go straight to LOCKED.
  - Otherwise stay in HUNT.
- VERIFY:
  - good(lane_o): good_cnt++; on reaching LOCK_CNT go to LOCKED, bad_cnt = 0.
  - Any bad word: go to HUNT, good_cnt = 0. The word is not re-hunted in the same cycle.
- LOCKED:
  - Every word: word_cnt++ (saturates at 2^32-1).
  - Good word: bad_cnt = 0.
  - Bad word: err_o = 1 for that cycle, err_cnt++ (saturates at all-ones, no wrap), bad_cnt++.
  - bad_cnt reaching UNLOCK_CNT: go to HUNT, locked_o = 0 next cycle, lane_o retained until the next acquisition.
  - Errors are never counted in HUNT or VERIFY.
- en_i = 0:
  - Synchronous return to HUNT; good_cnt and bad_cnt cleared; err_o = 0.
  - err_cnt_o and word_cnt_o are held.
- cnt_clr_i:
  - Clears err_cnt_o and word_cnt_o on the next edge.
  - Clear wins over a simultaneous increment (result 0), but err_o still pulses.
  - State is unaffected.
- Reset mid-lock: immediate asynchronous return to the reset values; no partial state survives.

Test Plan:
- Reset, then drive the default pattern with is_k = 8'h01 each cycle -> state HUNT→VERIFY after edge 1, LOCKED after edge 4; lane_o = 0; err_cnt_o = 0; word_cnt_o increments from edge 5.
- Drive the pattern rotated by 4 lanes (data 64'h00CA_FE1C_0000_0000, is_k 8'h10) -> lock with lane_o = 4.
- While locked, inject 3 corrupted words (byte 1 = 0xFF) then good words -> 3 err_o pulses, err_cnt_o = 3, locked_o stays 1.
- While locked, inject 4 consecutive words with rx_disp_err_i = 8'h02 -> err_cnt_o +4; locked_o falls the cycle after the 4th; state HUNT.
- In HUNT, drive is_k = 8'h11 with otherwise valid data -> remains HUNT. In VERIFY, one bad word -> HUNT, followed by full re-acquisition.
- Preload err_cnt_o to all-ones (force) and inject an error -> stays all-ones. Assert cnt_clr_i with a simultaneous error -> err_cnt_o = 0, err_o = 1. Assert rx_rst_i mid-lock -> all outputs 0 immediately.
